// File: rtl/vecgate_arbiter.sv
// Round-robin arbiter in front of a single 3-op vector gate unit.
// One operation is in flight at a time: IDLE (accept) -> EXEC (compute) -> RESP (handshake).
module vecgate_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 3,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*W-1:0]   a_flat,
   input  logic [NREQ*W-1:0]   b_flat,
   input  logic [NREQ*2-1:0]   op_flat,
   output logic [NREQ-1:0]     gnt,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [2*W-1:0]      rsp_data,
   output logic                rsp_err,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    win_q, win_d;
   logic [IDW-1:0]    pick;
   logic              found;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [2*W-1:0]    rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   function automatic logic [2*W-1:0] gate(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
      logic [2*W-1:0] r;
      case (op)
         2'b00:   r = {{W{1'b0}}, a | b};
         2'b01:   r = {{(2*W-1){1'b0}}, (|a) || (|b)};
         2'b10:   r = {~b, ~a};
         default: r = '0;
      endcase
      return r;
   endfunction

   // First set request at or after the pointer, wrapping at NREQ-1.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[rr_index(ptr_q, k)]) begin
            found = 1'b1;
            pick  = rr_index(ptr_q, k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      win_d       = win_q;
      gnt_d       = '0;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               win_d = pick;
               a_d   = a_flat[pick*W +: W];
               b_d   = b_flat[pick*W +: W];
               op_d  = op_flat[pick*2 +: 2];
               gnt_d = NREQ'(1) << pick;
               ptr_d = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
            end
         end
         EXEC: begin
            rsp_data_d  = gate(a_q, b_q, op_q);
            rsp_err_d   = (op_q == 2'b11);
            rsp_id_d    = win_q;
            rsp_valid_d = 1'b1;
         end
         RESP: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Captured operands are only read in EXEC, so they need no reset.
   always_ff @(posedge clk) begin
      win_q <= win_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vecgate_arbiter.sv
// Bench for vecgate_arbiter: directed scenarios plus a per-cycle reference model.
module tb_vecgate_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 3;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a_flat = '0;
   logic [NREQ*W-1:0] b_flat = '0;
   logic [NREQ*2-1:0] op_flat = '0;
   logic              rsp_ready = 1'b1;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [2*W-1:0]    rsp_data;
   logic              rsp_err;
   logic              busy;

   int n_chk = 0;
   int n_fail = 0;
   bit auto_drop = 1'b1;
   bit done = 1'b0;

   vecgate_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .op_flat(op_flat), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 computing, 2 response pending
   int       m_phase = 0;
   int       m_ptr = 0;
   int       m_win = 0;
   int       m_a = 0, m_b = 0, m_op = 0;
   logic [3:0] m_gnt = '0;
   bit       m_valid = 1'b0;
   int       m_id = 0;
   int       m_data = 0;
   bit       m_err = 1'b0;

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic int gate_ref(input int a, input int b, input int op);
      case (op)
         0:       return a | b;
         1:       return (a != 0 || b != 0) ? 1 : 0;
         2:       return (7 - b) * 8 + (7 - a);
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_ptr <= 0; m_gnt <= '0; m_valid <= 1'b0;
         m_id <= 0; m_data <= 0; m_err <= 1'b0;
      end else begin
         case (m_phase)
            0: if (rr_pick(req, m_ptr) >= 0) begin
                  m_win   <= rr_pick(req, m_ptr);
                  m_a     <= int'(a_flat[rr_pick(req, m_ptr)*W +: W]);
                  m_b     <= int'(b_flat[rr_pick(req, m_ptr)*W +: W]);
                  m_op    <= int'(op_flat[rr_pick(req, m_ptr)*2 +: 2]);
                  m_gnt   <= 4'(1) << rr_pick(req, m_ptr);
                  m_ptr   <= (rr_pick(req, m_ptr) + 1) % NREQ;
                  m_phase <= 1;
               end
            1: begin
                  m_gnt   <= '0;
                  m_data  <= gate_ref(m_a, m_b, m_op);
                  m_err   <= (m_op == 3);
                  m_id    <= m_win;
                  m_valid <= 1'b1;
                  m_phase <= 2;
               end
            default: if (rsp_ready) begin
                  m_valid <= 1'b0;
                  m_phase <= 0;
               end
         endcase
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (auto_drop) req = req & ~gnt;
   endtask

   task automatic set_opnd(input int i, input int a, input int b, input int op);
      a_flat[i*W +: W] = W'(a);
      b_flat[i*W +: W] = W'(b);
      op_flat[i*2 +: 2] = 2'(op);
   endtask

   task automatic wait_gnt(input logic [3:0] exp, input string nm, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (gnt == '0 && cyc < 20);
      check(nm, 32'(gnt), 32'(exp));
   endtask

   task automatic wait_rsp(input int id, input int data, input int err, input string nm);
      int cyc;
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         step();
         cyc++;
      end
      check({nm, "_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "_id"}, 32'(rsp_id), id);
      check({nm, "_data"}, 32'(rsp_data), data);
      check({nm, "_err"}, 32'(rsp_err), err);
   endtask

   task automatic wait_idle(input string nm);
      int cyc;
      cyc = 0;
      while (busy && cyc < 20) begin
         step();
         cyc++;
      end
      check({nm, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic run_op(input int i, input int a, input int b, input int op,
                         input int exp_data, input string nm);
      int c;
      set_opnd(i, a, b, op);
      req[i] = 1'b1;
      wait_gnt(4'(1) << i, {nm, "_gnt"}, c);
      a_flat = ~a_flat;
      b_flat = ~b_flat;
      op_flat = ~op_flat;
      wait_rsp(i, exp_data, (op == 3) ? 1 : 0, nm);
      wait_idle(nm);
   endtask

   initial begin
      int c, c2;
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_valid", 32'(rsp_valid), 0);
      check("rst_id", 32'(rsp_id), 0);
      check("rst_data", 32'(rsp_data), 0);
      check("rst_err", 32'(rsp_err), 0);
      check("rst_busy", 32'(busy), 0);

      fork
         begin
            while (!done) begin
               @(negedge clk);
               if (!done) begin
                  check("cmp_gnt", 32'(gnt), 32'(m_gnt));
                  check("cmp_valid", 32'(rsp_valid), 32'(m_valid));
                  check("cmp_id", 32'(rsp_id), m_id);
                  check("cmp_data", 32'(rsp_data), m_data);
                  check("cmp_err", 32'(rsp_err), 32'(m_err));
                  check("cmp_busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
               end
            end
         end
         begin
            // Basic OR from requester 0, with exact latency
            set_opnd(0, 3'b101, 3'b010, 0);
            req = 4'b0001;
            wait_gnt(4'b0001, "t1_gnt", c);
            step();
            check("t1_gnt_pulse", 32'(gnt), 0);
            check("t1_lat_valid", 32'(rsp_valid), 1);
            check("t1_data", 32'(rsp_data), 32'b000111);
            check("t1_id", 32'(rsp_id), 0);
            check("t1_err", 32'(rsp_err), 0);
            wait_idle("t1");

            run_op(1, 3'b000, 3'b000, 1, 6'b000000, "t2a");
            run_op(1, 3'b100, 3'b000, 1, 6'b000001, "t2b");
            run_op(1, 3'b101, 3'b011, 2, 6'b100010, "t2c");

            // Reserved op, then a normal one; both from requester 3 so ptr wraps to 0
            run_op(3, 3'b111, 3'b111, 3, 6'b000000, "t5a");
            run_op(3, 3'b001, 3'b010, 0, 6'b000011, "t5b");

            // All four requesting: rotation, twice
            for (int r = 0; r < 2; r++) begin
               set_opnd(0, 1, 2, 0);
               set_opnd(1, 6, 0, 1);
               set_opnd(2, 2, 5, 2);
               set_opnd(3, 7, 0, 0);
               req = 4'b1111;
               for (int k = 0; k < NREQ; k++)
                  wait_gnt(4'(1) << k, "t3_rr", c);
               wait_idle("t3");
            end

            // Backpressure with a pending requester
            rsp_ready = 1'b0;
            set_opnd(0, 3'b001, 3'b100, 0);
            req = 4'b0001;
            wait_gnt(4'b0001, "t4_gnt0", c);
            wait_rsp(0, 6'b000101, 0, "t4");
            set_opnd(2, 3, 3, 1);
            req[2] = 1'b1;
            for (int k = 0; k < 5; k++) begin
               step();
               check("t4_hold_valid", 32'(rsp_valid), 1);
               check("t4_hold_id", 32'(rsp_id), 0);
               check("t4_hold_data", 32'(rsp_data), 6'b000101);
               check("t4_hold_busy", 32'(busy), 1);
               check("t4_hold_gnt", 32'(gnt), 0);
            end
            rsp_ready = 1'b1;
            wait_gnt(4'b0100, "t4_gnt2", c);
            check("t4_gnt2_delay", c, 2);
            wait_rsp(2, 6'b000001, 0, "t4b");
            wait_idle("t4");

            // Persistent single requester: re-granted every 3 cycles
            auto_drop = 1'b0;
            set_opnd(1, 1, 1, 0);
            req = 4'b0010;
            wait_gnt(4'b0010, "tp_gnt1", c);
            wait_gnt(4'b0010, "tp_gnt2", c2);
            check("tp_spacing", c2, 3);
            req = '0;
            auto_drop = 1'b1;
            wait_idle("tp");

            // Asynchronous reset in RESP
            rsp_ready = 1'b0;
            set_opnd(3, 2, 1, 0);
            req = 4'b1000;
            wait_gnt(4'b1000, "t6_gnt", c);
            wait_rsp(3, 6'b000011, 0, "t6");
            req = '0;
            rsp_ready = 1'b1;
            #2 rst_n = 1'b0;
            #1;
            check("t6_rst_valid", 32'(rsp_valid), 0);
            check("t6_rst_gnt", 32'(gnt), 0);
            check("t6_rst_busy", 32'(busy), 0);
            #4 rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
               step();
               check("t6_no_stale", 32'(rsp_valid), 0);
            end
            set_opnd(0, 4, 4, 0);
            set_opnd(3, 0, 0, 0);
            req = 4'b1001;
            wait_gnt(4'b0001, "t6_ptr0", c);
            wait_rsp(0, 6'b000100, 0, "t6b");
            wait_gnt(4'b1000, "t6_next", c);
            wait_idle("t6");
            done = 1'b1;
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
